// File: rtl/multi_freq_counter.sv
// Multi-channel frequency counter: counts synchronised rising edges on each sensor
// input over a gated window, latches the counts into a serial readout shift register.
module multi_freq_counter #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int GW  = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [NCH-1:0] sens_in,
  input  logic [GW-1:0]  gate_len,
  input  logic           mode,
  input  logic           start,
  input  logic           stop,
  input  logic           shift_en,
  output logic           busy,
  output logic           done,
  output logic [NCH-1:0] ovf,
  output logic           sr_out,
  output logic [1:0]     dbg_state
);

  localparam int SRW = NCH * CW;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GW-1:0] GATE_ONE = GW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NCH-1:0]         sync1_q, sync1_d;
  logic [NCH-1:0]         sync2_q, sync2_d;
  logic [NCH-1:0]         sync3_q, sync3_d;
  logic [GW-1:0]          gate_q, gate_d;
  logic [GW-1:0]          len_q, len_d;
  logic                   mode_q, mode_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         ovf_int_q, ovf_int_d;
  logic [NCH-1:0]         ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [SRW-1:0]         sr_q, sr_d;
  logic [NCH-1:0]         edge_det;
  logic                   accept_start;
  logic [GW-1:0]          start_len;

  // Handshake: start is a level request, accepted only in IDLE while stop is low;
  // done is a single-cycle strobe qualifying a fresh shift register and ovf.
  assign accept_start = start && !stop;
  assign start_len    = (gate_len == '0) ? GATE_ONE : gate_len;
  assign edge_det     = sync2_q & ~sync3_q;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop outranks both start and gate expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_start) state_d = S_COUNT;
      S_COUNT: begin
        if (stop)                      state_d = S_IDLE;
        else if (gate_q <= GATE_ONE)   state_d = S_LATCH;
      end
      S_LATCH: state_d = (mode_q && !stop) ? S_COUNT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  assign done   = done_q;
  assign ovf    = ovf_q;
  assign sr_out = sr_q[SRW-1];

  // Datapath next-state
  always_comb begin
    sync1_d   = sens_in;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    gate_d    = gate_q;
    len_d     = len_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    sr_d      = sr_q;

    if (shift_en) sr_d = {sr_q[SRW-2:0], 1'b0};

    case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          gate_d = start_len;
          len_d  = start_len;
          mode_d = mode;
        end
      end
      S_COUNT: begin
        if (stop) begin
          cnt_d     = '0;
          ovf_int_d = '0;
          gate_d    = '0;
        end else begin
          gate_d = gate_q - GATE_ONE;
          for (int ch = 0; ch < NCH; ch++) begin
            if (edge_det[ch]) begin
              if (cnt_q[ch] == CNT_MAX) ovf_int_d[ch] = 1'b1;
              else                      cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
          end
        end
      end
      S_LATCH: begin
        // Load beats any shift requested in the same cycle
        sr_d      = cnt_q;
        ovf_d     = ovf_int_q;
        cnt_d     = '0;
        ovf_int_d = '0;
        done_d    = 1'b1;
        gate_d    = (mode_q && !stop) ? len_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      gate_q    <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_int_q <= '0;
      ovf_q     <= '0;
      done_q    <= 1'b0;
      sr_q      <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      gate_q    <= gate_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      sr_q      <= sr_d;
    end
  end

endmodule
